matrix_mult_ctrl: RTL and testbench
===================================

Name: matrix_mult_ctrl

Overview:
Sequencer for one systolic-array matrix-multiply pass inside matrix_mult.
- Loads ROW weight rows from the weight buffer into the array.
- Streams N input vectors from the input buffer.
- Writes the N result vectors returned by the array into the output buffer.
- Sits between the buffer memories (active-low cenb/wenb SRAM ports) and the PE array; the wrapper's start/done handshake drives it.

Parameters:
WIDTH, 8, element width in bits
ROW, 4, array rows (weight rows loaded per pass)
COL, 4, array columns (elements per result vector)
W_SIZE, 256, weight buffer depth
I_SIZE, 256, input buffer depth
O_SIZE, 256, output buffer depth

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active high
start_i  in  1  level start; a pass launches on its 0->1 edge while in IDLE
num_inputs_i  in  $clog2(I_SIZE)+1  input vectors per pass (N), sampled at launch
w_base_i / i_base_i / o_base_i  in  $clog2(W_SIZE) / $clog2(I_SIZE) / $clog2(O_SIZE)  buffer base addresses, sampled at launch
wb_mem_cenb_o  out  1  weight buffer enable, active low
wb_mem_addr_o  out  $clog2(W_SIZE)  weight address
ib_mem_cenb_o  out  1  input buffer enable, active low
ib_mem_addr_o  out  $clog2(I_SIZE)  input address
sa_weight_en_o  out  1  array latches weight row this cycle
sa_weight_row_o  out  $clog2(ROW)  row index for sa_weight_en_o
sa_valid_o  out  1  ib read data valid to array
sa_result_valid_i  in  1  array result valid
sa_result_i  in  COL*WIDTH  array result vector
ob_mem_cenb_o / ob_mem_wenb_o  out  1 / 1  output buffer enable / write enable, active low
ob_mem_addr_o  out  $clog2(O_SIZE)  output address
ob_mem_data_o  out  COL*WIDTH  output write data
busy_o  out  1  high in any state except IDLE and DONE
done_o  out  1  pass complete
err_o  out  1  sticky: result received when none expected

Behaviour:
- Reset: state IDLE. All cenb/wenb = 1. Addresses, data, sa_weight_row_o = 0. sa_weight_en_o, sa_valid_o, busy_o, done_o, err_o = 0. Counters = 0. start_i edge register = 0.
- rst_i mid-operation aborts the pass. Nothing is written after the reset edge.
- FSM IDLE -> LOAD_W -> STREAM -> DRAIN -> DONE -> IDLE.
  - IDLE: on start_i rising edge, latch config and go to LOAD_W. start_i already high at reset release does not launch a pass.
  - LOAD_W: ROW cycles, k = 0..ROW-1. Drive wb_mem_cenb_o = 0 and wb_mem_addr_o = w_base + k (registered outputs). Then go to STREAM, or to DRAIN if N == 0.
  - STREAM: N cycles, j = 0..N-1. Drive ib_mem_cenb_o = 0 and ib_mem_addr_o = i_base + j. Then go to DRAIN.
  - DRAIN: wait until out_cnt == N, then go to DONE.
  - DONE: done_o = 1. Hold until start_i == 0, then go to IDLE with done_o = 0.
- Memory read latency is 1 cycle:
  - sa_weight_en_o and sa_weight_row_o = k assert the cycle after each weight read.
  - sa_valid_o asserts the cycle after each ib read. This holds across the STREAM->DRAIN boundary.
- Result writeback is accepted in STREAM or DRAIN when out_cnt < N:
  - The cycle after sa_result_valid_i, drive ob_mem_cenb_o = 0, ob_mem_wenb_o = 0, ob_mem_addr_o = o_base + out_cnt, and ob_mem_data_o = the registered sa_result_i.
  - out_cnt increments on acceptance.
- Results arriving in any other state, or with out_cnt == N, are dropped and set err_o. err_o is cleared only by reset.
- Address arithmetic is modulo the buffer depth (natural wrap of $clog2 width). Base + count past the end wraps to 0.
- N is saturated to I_SIZE.
- DONE is not entered while a result write is still pending; the last ob write precedes done_o by at least one cycle.

Optional Feature:
MATRIX_MULT_CTRL_PERF_EN
- Defined: adds output perf_cycles_o (32 bits).
  - Cleared at launch; counts every cycle in LOAD_W, STREAM and DRAIN; holds in DONE/IDLE.
  - Saturates at 2^32-1. Reset value 0.
- Undefined: port and counter are absent.

Decomposition:
- Package matrix_mult_pkg:
  - ctrl_state_e enum {IDLE, LOAD_W, STREAM, DRAIN, DONE}
  - ctrl_cfg_struct (num_inputs, w_base, i_base, o_base)
  - MEM_RD_LAT = 1
- One sub-module: mm_ctrl_writeback. Owns the out_cnt counter, ob port registers and the err_o flag; driven by the FSM state and the latched N / o_base.

Test Plan:
- ROW = 4, w_base = 10, N = 3, i_base = 20, o_base = 30; array model returns results 5 cycles after sa_valid -> wb addr 10..13 then ib addr 20..22 on consecutive cycles; sa_weight_en rows 0..3; ob writes addr 30..32 with matching data; done_o after the last write.
- N = 0 -> 4 weight reads, no ib reads, no ob writes; DONE reached on the cycle after the last weight read; err_o = 0.
- o_base = 254, N = 4, O_SIZE = 256 -> ob addresses 254, 255, 0, 1.
- Extra sa_result_valid_i pulse after 3 of 3 results, plus one in IDLE -> no extra ob write; err_o = 1 and held until rst_i.
- rst_i asserted during STREAM at j = 1 -> next cycle all cenb = 1 and state IDLE; start_i held high gives no relaunch until start_i drops and rises again.
- start_i held high through DONE -> done_o stays 1; start_i low -> IDLE, done_o = 0; new start edge with N = 2 completes correctly (with PERF_EN: perf_cycles_o = 4 + 2 + drain cycles).

Source files
------------

// File: rtl/matrix_mult_pkg.sv
// rtl/matrix_mult_pkg.sv - shared state, config types and constants for the matrix_mult sequencer
package matrix_mult_pkg;

  localparam int MEM_RD_LAT = 1;

  localparam int MM_W_SIZE = 256;
  localparam int MM_I_SIZE = 256;
  localparam int MM_O_SIZE = 256;
  localparam int MM_W_AW   = $clog2(MM_W_SIZE);
  localparam int MM_I_AW   = $clog2(MM_I_SIZE);
  localparam int MM_O_AW   = $clog2(MM_O_SIZE);
  localparam int MM_N_W    = MM_I_AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    DONE
  } ctrl_state_e;

  typedef struct packed {
    logic [MM_N_W-1:0]  num_inputs;
    logic [MM_W_AW-1:0] w_base;
    logic [MM_I_AW-1:0] i_base;
    logic [MM_O_AW-1:0] o_base;
  } ctrl_cfg_struct;

  // A pass never streams more vectors than the input buffer holds.
  function automatic logic [MM_N_W-1:0] sat_num_inputs(input logic [MM_N_W-1:0] n);
    logic [MM_N_W-1:0] cap;
    cap = MM_N_W'(MM_I_SIZE);
    return (n > cap) ? cap : n;
  endfunction

endpackage

// File: rtl/mm_ctrl_writeback.sv
// rtl/mm_ctrl_writeback.sv - accepts array results into the output buffer and flags unexpected ones
module mm_ctrl_writeback
  import matrix_mult_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int COL    = 4,
  parameter int I_SIZE = MM_I_SIZE,
  parameter int O_SIZE = MM_O_SIZE
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clear_i,
  input  ctrl_state_e               state_i,
  input  logic [$clog2(I_SIZE):0]   num_inputs_i,
  input  logic [$clog2(O_SIZE)-1:0] o_base_i,
  input  logic                      sa_result_valid_i,
  input  logic [COL*WIDTH-1:0]      sa_result_i,
  output logic                      ob_mem_cenb_o,
  output logic                      ob_mem_wenb_o,
  output logic [$clog2(O_SIZE)-1:0] ob_mem_addr_o,
  output logic [COL*WIDTH-1:0]      ob_mem_data_o,
  output logic [$clog2(I_SIZE):0]   out_cnt_o,
  output logic                      err_o
);

  localparam int O_AW = $clog2(O_SIZE);
  localparam int N_W  = $clog2(I_SIZE) + 1;

  logic                 window;
  logic                 accept;
  logic [N_W-1:0]       out_cnt_q;
  logic                 ob_cenb_q;
  logic [O_AW-1:0]      ob_addr_q;
  logic [COL*WIDTH-1:0] ob_data_q;
  logic                 err_q;

  assign window = (state_i == STREAM) || (state_i == DRAIN);
  assign accept = sa_result_valid_i && window && (out_cnt_q < num_inputs_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_cnt_q <= '0;
      ob_cenb_q <= 1'b1;
      ob_addr_q <= '0;
      ob_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      ob_cenb_q <= ~accept;
      if (accept) begin
        ob_addr_q <= o_base_i + out_cnt_q[O_AW-1:0];
        ob_data_q <= sa_result_i;
      end
      if (clear_i) begin
        out_cnt_q <= '0;
      end else if (accept) begin
        out_cnt_q <= out_cnt_q + N_W'(1);
      end
      if (sa_result_valid_i && !accept) begin
        err_q <= 1'b1;
      end
    end
  end

  // Enable and write-enable always move together: this port only writes.
  assign ob_mem_cenb_o = ob_cenb_q;
  assign ob_mem_wenb_o = ob_cenb_q;
  assign ob_mem_addr_o = ob_addr_q;
  assign ob_mem_data_o = ob_data_q;
  assign out_cnt_o     = out_cnt_q;
  assign err_o         = err_q;

endmodule

// File: rtl/matrix_mult_ctrl.sv
// rtl/matrix_mult_ctrl.sv - weight-load / stream / drain sequencer for one systolic-array pass
// Optional perf_cycles_o busy-cycle counter when MATRIX_MULT_CTRL_PERF_EN is defined.
module matrix_mult_ctrl
  import matrix_mult_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ROW    = 4,
  parameter int COL    = 4,
  parameter int W_SIZE = MM_W_SIZE,
  parameter int I_SIZE = MM_I_SIZE,
  parameter int O_SIZE = MM_O_SIZE
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [$clog2(I_SIZE):0]   num_inputs_i,
  input  logic [$clog2(W_SIZE)-1:0] w_base_i,
  input  logic [$clog2(I_SIZE)-1:0] i_base_i,
  input  logic [$clog2(O_SIZE)-1:0] o_base_i,
  output logic                      wb_mem_cenb_o,
  output logic [$clog2(W_SIZE)-1:0] wb_mem_addr_o,
  output logic                      ib_mem_cenb_o,
  output logic [$clog2(I_SIZE)-1:0] ib_mem_addr_o,
  output logic                      sa_weight_en_o,
  output logic [$clog2(ROW)-1:0]    sa_weight_row_o,
  output logic                      sa_valid_o,
  input  logic                      sa_result_valid_i,
  input  logic [COL*WIDTH-1:0]      sa_result_i,
  output logic                      ob_mem_cenb_o,
  output logic                      ob_mem_wenb_o,
  output logic [$clog2(O_SIZE)-1:0] ob_mem_addr_o,
  output logic [COL*WIDTH-1:0]      ob_mem_data_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o
`ifdef MATRIX_MULT_CTRL_PERF_EN
  ,
  output logic [31:0]               perf_cycles_o
`endif
);

  localparam int W_AW = $clog2(W_SIZE);
  localparam int I_AW = $clog2(I_SIZE);
  localparam int N_W  = I_AW + 1;
  localparam int R_W  = $clog2(ROW);

  ctrl_state_e    state_q, state_d;
  ctrl_cfg_struct cfg_q, cfg_d;
  logic [N_W-1:0] cnt_q, cnt_d;
  logic [N_W-1:0] out_cnt;
  logic           start_q;
  logic           armed_q;
  logic           launch;

  logic            wb_cenb_q, wb_cenb_d;
  logic [W_AW-1:0] wb_addr_q, wb_addr_d;
  logic [R_W-1:0]  wb_row_q, wb_row_d;
  logic            ib_cenb_q, ib_cenb_d;
  logic [I_AW-1:0] ib_addr_q, ib_addr_d;

  logic [MEM_RD_LAT-1:0]          w_en_pipe_q;
  logic [MEM_RD_LAT-1:0]          ib_vld_pipe_q;
  logic [MEM_RD_LAT-1:0][R_W-1:0] w_row_pipe_q;

  // armed_q stays low until start_i has been seen low after reset, so a
  // start level already present at reset release cannot launch a pass.
  assign launch = (state_q == IDLE) && start_i && !start_q && armed_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cfg_q     <= '0;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      armed_q   <= 1'b0;
      wb_cenb_q <= 1'b1;
      wb_addr_q <= '0;
      wb_row_q  <= '0;
      ib_cenb_q <= 1'b1;
      ib_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      cnt_q     <= cnt_d;
      start_q   <= start_i;
      armed_q   <= armed_q | ~start_i;
      wb_cenb_q <= wb_cenb_d;
      wb_addr_q <= wb_addr_d;
      wb_row_q  <= wb_row_d;
      ib_cenb_q <= ib_cenb_d;
      ib_addr_q <= ib_addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cfg_d   = cfg_q;
    case (state_q)
      IDLE: begin
        if (launch) begin
          state_d          = LOAD_W;
          cnt_d            = '0;
          cfg_d.num_inputs = sat_num_inputs(num_inputs_i);
          cfg_d.w_base     = w_base_i;
          cfg_d.i_base     = i_base_i;
          cfg_d.o_base     = o_base_i;
        end
      end
      LOAD_W: begin
        if (cnt_q == N_W'(ROW - 1)) begin
          cnt_d   = '0;
          state_d = (cfg_q.num_inputs == '0) ? DRAIN : STREAM;
        end else begin
          cnt_d = cnt_q + N_W'(1);
        end
      end
      STREAM: begin
        if (cnt_q == cfg_q.num_inputs - N_W'(1)) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + N_W'(1);
        end
      end
      DRAIN: begin
        if (out_cnt == cfg_q.num_inputs) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!start_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read ports are registered off the current state; addresses hold between reads.
  always_comb begin
    wb_cenb_d = 1'b1;
    wb_addr_d = wb_addr_q;
    wb_row_d  = wb_row_q;
    ib_cenb_d = 1'b1;
    ib_addr_d = ib_addr_q;
    case (state_q)
      LOAD_W: begin
        wb_cenb_d = 1'b0;
        wb_addr_d = cfg_q.w_base + cnt_q[W_AW-1:0];
        wb_row_d  = cnt_q[R_W-1:0];
      end
      STREAM: begin
        ib_cenb_d = 1'b0;
        ib_addr_d = cfg_q.i_base + cnt_q[I_AW-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_en_pipe_q   <= '0;
      ib_vld_pipe_q <= '0;
      w_row_pipe_q  <= '0;
    end else begin
      w_en_pipe_q[0]   <= ~wb_cenb_q;
      ib_vld_pipe_q[0] <= ~ib_cenb_q;
      w_row_pipe_q[0]  <= wb_row_q;
      for (int i = 1; i < MEM_RD_LAT; i++) begin
        w_en_pipe_q[i]   <= w_en_pipe_q[i-1];
        ib_vld_pipe_q[i] <= ib_vld_pipe_q[i-1];
        w_row_pipe_q[i]  <= w_row_pipe_q[i-1];
      end
    end
  end

  assign wb_mem_cenb_o   = wb_cenb_q;
  assign wb_mem_addr_o   = wb_addr_q;
  assign ib_mem_cenb_o   = ib_cenb_q;
  assign ib_mem_addr_o   = ib_addr_q;
  assign sa_weight_en_o  = w_en_pipe_q[MEM_RD_LAT-1];
  assign sa_weight_row_o = w_row_pipe_q[MEM_RD_LAT-1];
  assign sa_valid_o      = ib_vld_pipe_q[MEM_RD_LAT-1];
  assign busy_o          = (state_q == LOAD_W) || (state_q == STREAM) || (state_q == DRAIN);
  assign done_o          = (state_q == DONE);

  mm_ctrl_writeback #(
    .WIDTH  (WIDTH),
    .COL    (COL),
    .I_SIZE (I_SIZE),
    .O_SIZE (O_SIZE)
  ) u_writeback (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .clear_i           (launch),
    .state_i           (state_q),
    .num_inputs_i      (cfg_q.num_inputs),
    .o_base_i          (cfg_q.o_base),
    .sa_result_valid_i (sa_result_valid_i),
    .sa_result_i       (sa_result_i),
    .ob_mem_cenb_o     (ob_mem_cenb_o),
    .ob_mem_wenb_o     (ob_mem_wenb_o),
    .ob_mem_addr_o     (ob_mem_addr_o),
    .ob_mem_data_o     (ob_mem_data_o),
    .out_cnt_o         (out_cnt),
    .err_o             (err_o)
  );

`ifdef MATRIX_MULT_CTRL_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_q <= '0;
    end else if (launch) begin
      perf_q <= '0;
    end else if (busy_o && (perf_q != '1)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles_o = perf_q;
`endif

endmodule

// File: tb/tb_matrix_mult_ctrl.sv
// tb/tb_matrix_mult_ctrl.sv - randomized self-checking bench for matrix_mult_ctrl
module tb_matrix_mult_ctrl;

  localparam int WIDTH = 8;
  localparam int ROW   = 4;
  localparam int COL   = 4;
  localparam int DEPTH = 256;
  localparam int DW    = COL * WIDTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i, start_i;
  logic [8:0]    num_inputs_i;
  logic [7:0]    w_base_i, i_base_i, o_base_i;
  logic          wb_mem_cenb_o, ib_mem_cenb_o;
  logic [7:0]    wb_mem_addr_o, ib_mem_addr_o, ob_mem_addr_o;
  logic          sa_weight_en_o, sa_valid_o;
  logic [1:0]    sa_weight_row_o;
  logic          sa_result_valid_i;
  logic [DW-1:0] sa_result_i;
  logic          ob_mem_cenb_o, ob_mem_wenb_o;
  logic [DW-1:0] ob_mem_data_o;
  logic          busy_o, done_o, err_o;
`ifdef MATRIX_MULT_CTRL_PERF_EN
  logic [31:0]   perf_cycles_o;
`endif

  logic          mdl_vld, inj_vld;
  logic [DW-1:0] mdl_dat;
  assign sa_result_valid_i = mdl_vld | inj_vld;
  assign sa_result_i       = mdl_dat;

  matrix_mult_ctrl #(
    .WIDTH(WIDTH), .ROW(ROW), .COL(COL),
    .W_SIZE(DEPTH), .I_SIZE(DEPTH), .O_SIZE(DEPTH)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .start_i           (start_i),
    .num_inputs_i      (num_inputs_i),
    .w_base_i          (w_base_i),
    .i_base_i          (i_base_i),
    .o_base_i          (o_base_i),
    .wb_mem_cenb_o     (wb_mem_cenb_o),
    .wb_mem_addr_o     (wb_mem_addr_o),
    .ib_mem_cenb_o     (ib_mem_cenb_o),
    .ib_mem_addr_o     (ib_mem_addr_o),
    .sa_weight_en_o    (sa_weight_en_o),
    .sa_weight_row_o   (sa_weight_row_o),
    .sa_valid_o        (sa_valid_o),
    .sa_result_valid_i (sa_result_valid_i),
    .sa_result_i       (sa_result_i),
    .ob_mem_cenb_o     (ob_mem_cenb_o),
    .ob_mem_wenb_o     (ob_mem_wenb_o),
    .ob_mem_addr_o     (ob_mem_addr_o),
    .ob_mem_data_o     (ob_mem_data_o),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .err_o             (err_o)
`ifdef MATRIX_MULT_CTRL_PERF_EN
    ,
    .perf_cycles_o     (perf_cycles_o)
`endif
  );

  typedef struct {
    int            cyc;
    int            addr;
    logic [DW-1:0] data;
  } ev_t;

  ev_t           wb_q[$], row_q[$], ib_q[$], sv_q[$], ob_q[$];
  logic [DW-1:0] res_q[$];
  int            due_q[$];
  int            cyc      = 0;
  int            lat      = 5;
  int            done_cyc = -1;
  int            busy_cyc = -1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Bus monitor plus array model: each sa_valid produces one result lat cycles later.
  initial begin
    mdl_vld = 1'b0;
    mdl_dat = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_i) begin
        due_q.delete();
        mdl_vld = 1'b0;
      end else begin
        if (!wb_mem_cenb_o) wb_q.push_back('{cyc, int'(wb_mem_addr_o), '0});
        if (sa_weight_en_o) row_q.push_back('{cyc, int'(sa_weight_row_o), '0});
        if (!ib_mem_cenb_o) ib_q.push_back('{cyc, int'(ib_mem_addr_o), '0});
        if (sa_valid_o)     sv_q.push_back('{cyc, 0, '0});
        if (!ob_mem_cenb_o && !ob_mem_wenb_o) ob_q.push_back('{cyc, int'(ob_mem_addr_o), ob_mem_data_o});
        if (done_o && done_cyc < 0) done_cyc = cyc;
        if (busy_o && busy_cyc < 0) busy_cyc = cyc;
        if (sa_valid_o) due_q.push_back(cyc + lat);
        mdl_vld = 1'b0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
          void'(due_q.pop_front());
          mdl_vld = 1'b1;
          mdl_dat = DW'($urandom);
          res_q.push_back(mdl_dat);
        end
      end
    end
  end

  task automatic clear_logs();
    wb_q.delete(); row_q.delete(); ib_q.delete(); sv_q.delete(); ob_q.delete();
    res_q.delete();
    done_cyc = -1;
    busy_cyc = -1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic run_pass(input int n, input int wb, input int ib, input int ob,
                          input int hold, input bit inj, input bit exp_err);
    int nn, to, w_last;
    nn = (n > DEPTH) ? DEPTH : n;
    clear_logs();
    num_inputs_i = 9'(n);
    w_base_i     = 8'(wb);
    i_base_i     = 8'(ib);
    o_base_i     = 8'(ob);
    start_i      = 1'b1;
    to = 0;
    do begin
      @(negedge clk);
      to++;
    end while (!done_o && to < 3000);
    chk("done_seen", done_o, 1);
    for (int h = 0; h < hold; h++) begin
      inj_vld = inj && (h == 0);
      @(negedge clk);
      chk("done_hold", done_o, 1);
    end
    inj_vld = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
    chk("done_drop", done_o, 0);
    chk("idle_busy", busy_o, 0);

    chk("wb_cnt", wb_q.size(), ROW);
    foreach (wb_q[k]) begin
      chk("wb_addr", wb_q[k].addr, (wb + k) % DEPTH);
      chk("wb_cyc", wb_q[k].cyc - wb_q[0].cyc, k);
    end
    w_last = (wb_q.size() > 0) ? wb_q[wb_q.size()-1].cyc : 0;
    chk("row_cnt", row_q.size(), ROW);
    foreach (row_q[k]) begin
      chk("row_idx", row_q[k].addr, k);
      if (k < wb_q.size()) chk("row_cyc", row_q[k].cyc, wb_q[k].cyc + 1);
    end
    chk("ib_cnt", ib_q.size(), nn);
    foreach (ib_q[j]) begin
      chk("ib_addr", ib_q[j].addr, (ib + j) % DEPTH);
      chk("ib_cyc", ib_q[j].cyc, w_last + 1 + j);
    end
    chk("sv_cnt", sv_q.size(), nn);
    foreach (sv_q[j]) begin
      if (j < ib_q.size()) chk("sv_cyc", sv_q[j].cyc, ib_q[j].cyc + 1);
    end
    chk("ob_cnt", ob_q.size(), nn);
    foreach (ob_q[m]) begin
      chk("ob_addr", ob_q[m].addr, (ob + m) % DEPTH);
      if (m < res_q.size()) chk("ob_data", ob_q[m].data, res_q[m]);
      if (m < sv_q.size())  chk("ob_cyc", ob_q[m].cyc, sv_q[m].cyc + lat + 1);
    end
    if (nn == 0) chk("done_n0_cyc", done_cyc, w_last + 1);
    else if (ob_q.size() > 0) chk("done_after_wr", done_cyc > ob_q[ob_q.size()-1].cyc, 1);
    chk("err", err_o, exp_err);
`ifdef MATRIX_MULT_CTRL_PERF_EN
    chk("perf", perf_cycles_o, done_cyc - busy_cyc);
    chk("perf_min", perf_cycles_o >= ROW + nn, 1);
`endif
  endtask

  initial begin
    int to;
    rst_i        = 1'b1;
    start_i      = 1'b0;
    inj_vld      = 1'b0;
    num_inputs_i = '0;
    w_base_i     = '0;
    i_base_i     = '0;
    o_base_i     = '0;
    repeat (3) @(negedge clk);
    chk("rst_wb_cenb", wb_mem_cenb_o, 1);
    chk("rst_ib_cenb", ib_mem_cenb_o, 1);
    chk("rst_ob_cenb", ob_mem_cenb_o, 1);
    chk("rst_ob_wenb", ob_mem_wenb_o, 1);
    chk("rst_wb_addr", wb_mem_addr_o, 0);
    chk("rst_ob_addr", ob_mem_addr_o, 0);
    chk("rst_w_en", sa_weight_en_o, 0);
    chk("rst_w_row", sa_weight_row_o, 0);
    chk("rst_sa_valid", sa_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    rst_i = 1'b0;
    @(negedge clk);

    lat = 5;
    run_pass(3, 10, 20, 30, 0, 0, 0);
    run_pass(0, int'($urandom_range(0, 255)), 0, 0, 0, 0, 0);
    run_pass(4, 7, 9, 254, 0, 0, 0);

    // Stray results: one while DONE after a full pass, one in IDLE.
    run_pass(3, 1, 2, 3, 3, 1, 1);
    inj_vld = 1'b1;
    @(negedge clk);
    inj_vld = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_no_wr", ob_q.size(), 3);
    chk("err_sticky", err_o, 1);
    run_pass(2, 5, 6, 7, 0, 0, 1);
    do_reset();
    @(negedge clk);
    chk("err_clr", err_o, 0);

    // Abort mid-stream with start_i still high.
    clear_logs();
    num_inputs_i = 9'd8;
    w_base_i     = 8'd40;
    i_base_i     = 8'd50;
    o_base_i     = 8'd60;
    start_i      = 1'b1;
    to = 0;
    do begin
      @(negedge clk);
      to++;
    end while (ib_mem_cenb_o && to < 100);
    chk("abort_reach", ib_mem_cenb_o, 0);
    rst_i = 1'b1;
    @(negedge clk);
    chk("abort_wb_cenb", wb_mem_cenb_o, 1);
    chk("abort_ib_cenb", ib_mem_cenb_o, 1);
    chk("abort_ob_cenb", ob_mem_cenb_o, 1);
    chk("abort_busy", busy_o, 0);
    chk("abort_sa_valid", sa_valid_o, 0);
    @(negedge clk);
    rst_i = 1'b0;
    clear_logs();
    repeat (10) @(negedge clk);
    chk("no_relaunch_busy", busy_o, 0);
    chk("no_relaunch_wb", wb_q.size(), 0);
    chk("no_relaunch_ob", ob_q.size(), 0);
    start_i = 1'b0;
    @(negedge clk);
    run_pass(3, 100, 200, 250, 0, 0, 0);

    run_pass(2, 11, 12, 13, 5, 0, 0);
    run_pass(300, 3, 17, 129, 0, 0, 0);

    for (int r = 0; r < 6; r++) begin
      lat = int'($urandom_range(3, 8));
      run_pass(int'($urandom_range(1, 7)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 2)), 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
